// File: rtl/regfile_mp_sb.sv
// Integer register file with N combinational read ports, one write port,
// optional write-to-read bypass, hardwired-zero x0, a per-register pending
// scoreboard and a sequential clear engine (one register per cycle).
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_we/i_rd_addr/i_rd write port
//   i_rsv/i_rsv_addr    reserve (mark pending) a register
//   i_clr               start sequential clear
//   i_rs_addr           packed read addresses, port p at [p*AW +: AW]
//   o_rs                packed read data, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   o_rs_pend           pending flag of each addressed register
//   o_busy              clear engine active
module regfile_mp_sb #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned NUM_RD_PORTS = 2,
  parameter int unsigned BYPASS       = 1,
  parameter int unsigned ZERO_REG     = 1,
  localparam int unsigned AW          = $clog2(NUM_REGS)
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_we,
  input  logic [AW-1:0]                      i_rd_addr,
  input  logic [DATA_WIDTH-1:0]              i_rd,
  input  logic                               i_rsv,
  input  logic [AW-1:0]                      i_rsv_addr,
  input  logic                               i_clr,
  input  logic [NUM_RD_PORTS*AW-1:0]         i_rs_addr,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] o_rs,
  output logic [NUM_RD_PORTS-1:0]            o_rs_pend,
  output logic                               o_busy
);

  localparam logic [AW:0]   NREG = (AW+1)'(NUM_REGS);
  localparam logic [AW-1:0] LAST = AW'(NUM_REGS - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  state_e                  state_q, state_d;
  logic [AW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]     pend_q, pend_d;
  logic                    we_ok, rsv_ok;

  // Address names a real, writable register (in range and not the zero register).
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < NREG) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Writes and reservations are only accepted while the clear engine is idle.
  assign we_ok  = i_we  && (state_q == S_IDLE) && addr_ok(i_rd_addr);
  assign rsv_ok = i_rsv && (state_q == S_IDLE) && addr_ok(i_rsv_addr);
  assign o_busy = (state_q == S_CLEAR);

  // Next-state: write, then reservation (so reserve+write leaves pend set), clear engine.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    regs_d  = regs_q;
    pend_d  = pend_q;
    unique case (state_q)
      S_IDLE: begin
        if (we_ok) begin
          regs_d[i_rd_addr] = i_rd;
          pend_d[i_rd_addr] = 1'b0;
        end
        if (rsv_ok) begin
          pend_d[i_rsv_addr] = 1'b1;
        end
        if (i_clr) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        regs_d[cnt_q] = '0;
        pend_d[cnt_q] = 1'b0;
        cnt_d         = cnt_q + AW'(1);
        if (cnt_q == LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      regs_q  <= regs_d;
    end
  end

  // Combinational read ports with optional same-cycle bypass of the accepted write.
  always_comb begin
    logic [AW-1:0] a;
    a         = '0;
    o_rs      = '0;
    o_rs_pend = '0;
    for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
      a = i_rs_addr[p*AW +: AW];
      if (addr_ok(a)) begin
        if ((BYPASS != 0) && we_ok && (i_rd_addr == a)) begin
          o_rs[p*DATA_WIDTH +: DATA_WIDTH] = i_rd;
          o_rs_pend[p]                     = 1'b0;
        end else begin
          o_rs[p*DATA_WIDTH +: DATA_WIDTH] = regs_q[a];
          o_rs_pend[p]                     = pend_q[a];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: default config, a no-bypass copy and a
// 24-register / 3-port copy share the control inputs; expectations go through
// a scoreboard queue and are compared when the outputs are sampled.
module tb_regfile_mp_sb;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, we, rsv, clr;
  logic [AW-1:0]     rd_addr, rsv_addr;
  logic [DW-1:0]     rd;
  logic [2*AW-1:0]   rs_addr;
  logic [2*DW-1:0]   rs_b, rs_nb;
  logic [1:0]        pend_b, pend_nb;
  logic              busy_b, busy_nb;
  logic [3*AW-1:0]   rs_addr24;
  logic [3*DW-1:0]   rs_24;
  logic [2:0]        pend_24;
  logic              busy_24;

  regfile_mp_sb dut (
    .i_clk(clk), .i_rst(rst), .i_we(we), .i_rd_addr(rd_addr), .i_rd(rd),
    .i_rsv(rsv), .i_rsv_addr(rsv_addr), .i_clr(clr), .i_rs_addr(rs_addr),
    .o_rs(rs_b), .o_rs_pend(pend_b), .o_busy(busy_b)
  );

  regfile_mp_sb #(.BYPASS(0)) dut_nb (
    .i_clk(clk), .i_rst(rst), .i_we(we), .i_rd_addr(rd_addr), .i_rd(rd),
    .i_rsv(rsv), .i_rsv_addr(rsv_addr), .i_clr(clr), .i_rs_addr(rs_addr),
    .o_rs(rs_nb), .o_rs_pend(pend_nb), .o_busy(busy_nb)
  );

  regfile_mp_sb #(.NUM_REGS(24), .NUM_RD_PORTS(3)) dut24 (
    .i_clk(clk), .i_rst(rst), .i_we(we), .i_rd_addr(rd_addr), .i_rd(rd),
    .i_rsv(rsv), .i_rsv_addr(rsv_addr), .i_clr(clr), .i_rs_addr(rs_addr24),
    .o_rs(rs_24), .o_rs_pend(pend_24), .o_busy(busy_24)
  );

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [63:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic pop_chk(input logic [63:0] obs);
    sb_t e;
    if (sb_q.size() == 0) begin
      chk("scoreboard_underflow", 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      chk(e.tag, obs, e.exp);
    end
  endtask

  task automatic idle();
    we = 1'b0; rsv = 1'b0; clr = 1'b0;
    rd = '0; rd_addr = '0; rsv_addr = '0;
  endtask

  task automatic set_rs(input int a0, input int a1);
    rs_addr = {AW'(a1), AW'(a0)};
  endtask

  function automatic logic [DW-1:0] fv(input int i);
    return 32'hC0DE_0000 + DW'(i);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nbusy;
    idle();
    rst = 1'b1;
    rs_addr = '0;
    rs_addr24 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    @(negedge clk); set_rs(5, 5);
    push("rst_rs", 64'd0); push("rst_pend", 64'd0); push("rst_busy", 64'd0);
    #1; pop_chk(rs_b); pop_chk(pend_b); pop_chk(busy_b);

    // Bypass vs no bypass on write to x7
    @(negedge clk); we = 1'b1; rd_addr = 7; rd = 32'hDEADBEEF; set_rs(7, 0);
    push("byp_w7", 64'hDEADBEEF); push("byp_w7_pend", 64'd0); push("nobyp_w7_old", 64'd0);
    #1; pop_chk(rs_b[DW-1:0]); pop_chk(pend_b[0]); pop_chk(rs_nb[DW-1:0]);
    @(negedge clk); idle();
    push("nobyp_w7_next", 64'hDEADBEEF); push("byp_w7_next", 64'hDEADBEEF);
    #1; pop_chk(rs_nb[DW-1:0]); pop_chk(rs_b[DW-1:0]);

    // x0: write and reservation ignored
    @(negedge clk); we = 1'b1; rd_addr = 0; rd = 32'h1234; rsv = 1'b1; rsv_addr = 0; set_rs(0, 0);
    push("x0_byp", 64'd0); push("x0_byp_pend", 64'd0);
    #1; pop_chk(rs_b); pop_chk(pend_b);
    @(negedge clk); idle();
    push("x0_after", 64'd0); push("x0_after_pend", 64'd0); push("x0_nb", 64'd0); push("x0_nb_pend", 64'd0);
    #1; pop_chk(rs_b); pop_chk(pend_b); pop_chk(rs_nb); pop_chk(pend_nb);

    // Reservation / write interplay on x3 and x4
    @(negedge clk); rsv = 1'b1; rsv_addr = 3; set_rs(3, 3);
    push("rsv3_same", 64'd0);
    #1; pop_chk(pend_b);
    @(negedge clk); idle();
    push("rsv3_next", 64'd3);
    #1; pop_chk(pend_b);
    @(negedge clk); we = 1'b1; rd_addr = 3; rd = 32'h55;
    push("w3_byp", 64'h55); push("w3_byp_pend", 64'd0); push("w3_nb_old", 64'd0); push("w3_nb_pend", 64'd3);
    #1; pop_chk(rs_b[DW-1:0]); pop_chk(pend_b); pop_chk(rs_nb[DW-1:0]); pop_chk(pend_nb);
    @(negedge clk); idle();
    push("w3_next", 64'h55); push("w3_next_pend", 64'd0);
    #1; pop_chk(rs_b[DW-1:0]); pop_chk(pend_b);
    @(negedge clk); we = 1'b1; rd_addr = 4; rd = 32'h66; rsv = 1'b1; rsv_addr = 4; set_rs(4, 4);
    push("rw4_byp", 64'h66); push("rw4_byp_pend", 64'd0);
    #1; pop_chk(rs_b[2*DW-1:DW]); pop_chk(pend_b);
    @(negedge clk); idle();
    push("rw4_data", 64'h66); push("rw4_pend", 64'd3); push("rw4_nb_pend", 64'd3);
    #1; pop_chk(rs_b[2*DW-1:DW]); pop_chk(pend_b); pop_chk(pend_nb);

    // Fill x1..x31 and read back
    for (int i = 1; i < 32; i++) begin
      @(negedge clk); we = 1'b1; rd_addr = AW'(i); rd = fv(i);
    end
    for (int i = 1; i < 32; i++) begin
      @(negedge clk); idle(); set_rs(i, i);
      push($sformatf("fill_x%0d", i), 64'(fv(i))); push($sformatf("fill_nb_x%0d", i), 64'(fv(i)));
      #1; pop_chk(rs_b[DW-1:0]); pop_chk(rs_nb[2*DW-1:DW]);
    end

    // Sequential clear
    @(negedge clk); rsv = 1'b1; rsv_addr = 4;
    @(negedge clk); idle(); clr = 1'b1;
    @(negedge clk); idle(); we = 1'b1; rd_addr = 20; rd = 32'hFFFF; set_rs(20, 4);
    push("clr_c0_busy", 64'd1); push("clr_c0_nobyp", 64'(fv(20))); push("clr_c0_pend4", 64'd2);
    #1; pop_chk(busy_b); pop_chk(rs_b[DW-1:0]); pop_chk(pend_b);
    @(negedge clk); idle(); set_rs(20, 20);
    push("clr_c1_busy", 64'd1); push("clr_c1_drop", 64'(fv(20)));
    #1; pop_chk(busy_b); pop_chk(rs_b[2*DW-1:DW]);
    @(negedge clk); set_rs(1, 31);
    push("clr_c2_busy", 64'd1); push("clr_c2_x1", 64'd0); push("clr_c2_x31", 64'(fv(31)));
    #1; pop_chk(busy_b); pop_chk(rs_b[DW-1:0]); pop_chk(rs_b[2*DW-1:DW]);
    nbusy = 3;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      if (!busy_b) break;
      nbusy++;
    end
    push("clr_busy_cycles", 64'd32);
    pop_chk(64'(nbusy));
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); set_rs(i, i);
      push($sformatf("clr_x%0d", i), 64'd0); push($sformatf("clr_pend_x%0d", i), 64'd0);
      push($sformatf("clr_nb_x%0d", i), 64'd0);
      #1; pop_chk(rs_b[DW-1:0]); pop_chk(pend_b); pop_chk(rs_nb[DW-1:0]);
    end

    // Reset in the middle of a clear
    @(negedge clk); we = 1'b1; rd_addr = 25; rd = 32'h77; rsv = 1'b1; rsv_addr = 26;
    @(negedge clk); idle(); clr = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk); clr = 1'b0; set_rs(25, 26);
      push($sformatf("rclr_busy_c%0d", k), 64'd1);
      #1; pop_chk(busy_b);
    end
    push("rclr_x25_pre", 64'h77); push("rclr_pend26_pre", 64'd2);
    pop_chk(rs_b[DW-1:0]); pop_chk(pend_b);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    push("rclr_busy_after", 64'd0); push("rclr_x25_after", 64'd0); push("rclr_pend_after", 64'd0);
    #1; pop_chk(busy_b); pop_chk(rs_b[DW-1:0]); pop_chk(pend_b);

    // 24-register, 3-port instance: out-of-range accesses and independent ports
    @(negedge clk); we = 1'b1; rd_addr = 30; rd = 32'h0BAD; rsv = 1'b1; rsv_addr = 30;
    rs_addr24 = {AW'(0), AW'(0), AW'(30)};
    push("r24_oor_byp", 64'd0); push("r24_oor_pend", 64'd0);
    #1; pop_chk(rs_24[DW-1:0]); pop_chk(pend_24);
    @(negedge clk); rd_addr = 24; rd = 32'h2424; rsv = 1'b0;
    push("r24_oor_after", 64'd0); push("r24_oor_after_pend", 64'd0);
    #1; pop_chk(rs_24[DW-1:0]); pop_chk(pend_24);
    @(negedge clk); rd_addr = 1; rd = 32'h11; rs_addr24 = {AW'(0), AW'(0), AW'(24)};
    push("r24_a24", 64'd0);
    #1; pop_chk(rs_24[DW-1:0]);
    @(negedge clk); rd_addr = 2; rd = 32'h22;
    @(negedge clk); rd_addr = 23; rd = 32'h2323;
    @(negedge clk); idle(); rs_addr24 = {AW'(23), AW'(2), AW'(1)};
    push("r24_p0_x1", 64'h11); push("r24_p1_x2", 64'h22); push("r24_p2_x23", 64'h2323); push("r24_pend", 64'd0);
    #1; pop_chk(rs_24[DW-1:0]); pop_chk(rs_24[2*DW-1:DW]); pop_chk(rs_24[3*DW-1:2*DW]); pop_chk(pend_24);

    if (sb_q.size() != 0) chk("scoreboard_leftover", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
